// File: rtl/tmr_recovery_sequencer.sv
// Recovery sequencer behind the TMR voter: freezes the cores, copies the register file and PC into a faulty core, then releases them.
// Optional per-core fault event counters are built when RECOVERY_FAULT_LOG_EN is defined.
module tmr_recovery_sequencer #(
    parameter int HOLD_CYCLES   = 2,
    parameter int VERIFY_CYCLES = 8,
    parameter int MAX_RETRY     = 2
) (
    input  logic        clk,
    input  logic        rst_in,
    input  logic [2:0]  Voter_state,
    input  logic [31:0] PC_Top,
    input  logic [31:0] rd_data_A,
    input  logic [31:0] rd_data_B,
    input  logic [31:0] rd_data_C,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_wd,
    output logic        rf_we_A,
    output logic        rf_we_B,
    output logic        rf_we_C,
    output logic        pc_we_A,
    output logic        pc_we_B,
    output logic        pc_we_C,
    output logic        core_hold,
    output logic        Recovery_mode,
    output logic        fatal,
    output logic [7:0]  fault_cnt_A,
    output logic [7:0]  fault_cnt_B,
    output logic [7:0]  fault_cnt_C
);

    localparam int CW = 16;

    typedef enum logic [2:0] {
        S_IDLE, S_HOLD, S_COPY, S_PCFIX, S_VERIFY, S_FATAL
    } state_t;

    state_t      r_state, w_next;
    logic [2:0]  r_fault, w_nextFault;
    logic [4:0]  r_idx, w_nextIdx;
    logic [CW-1:0] r_cnt, w_nextCnt;
    logic [7:0]  r_retry, w_nextRetry;
    logic        w_single, w_clean;

    assign w_single = (Voter_state == 3'b001) || (Voter_state == 3'b010) || (Voter_state == 3'b100);
    assign w_clean  = (Voter_state == 3'b000);

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
            r_fault <= 3'b000;
            r_idx   <= 5'd0;
            r_cnt   <= '0;
            r_retry <= 8'd0;
        end else begin
            r_state <= w_next;
            r_fault <= w_nextFault;
            r_idx   <= w_nextIdx;
            r_cnt   <= w_nextCnt;
            r_retry <= w_nextRetry;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_nextFault = r_fault;
        w_nextIdx   = r_idx;
        w_nextCnt   = r_cnt;
        w_nextRetry = r_retry;
        case (r_state)
            S_IDLE: begin
                if (w_single) begin
                    w_nextFault = Voter_state;
                    w_nextRetry = 8'd1;
                    w_nextCnt   = '0;
                    w_next      = S_HOLD;
                end else if (!w_clean) begin
                    w_next = S_FATAL;
                end
            end
            S_HOLD: begin
                if (r_cnt == CW'(HOLD_CYCLES - 1)) begin
                    w_nextIdx = 5'd1;
                    w_next    = S_COPY;
                end else begin
                    w_nextCnt = r_cnt + 1'b1;
                end
            end
            S_COPY: begin
                if (r_idx == 5'd31) begin
                    w_nextIdx = 5'd0;
                    w_next    = S_PCFIX;
                end else begin
                    w_nextIdx = r_idx + 5'd1;
                end
            end
            S_PCFIX: begin
                w_nextCnt = '0;
                w_next    = S_VERIFY;
            end
            S_VERIFY: begin
                // A re-flag of the same core is a retry; any other single core starts a fresh event
                if (w_single) begin
                    if (Voter_state != r_fault) begin
                        w_nextFault = Voter_state;
                        w_nextRetry = 8'd1;
                        w_nextCnt   = '0;
                        w_next      = S_HOLD;
                    end else if (r_retry < 8'(MAX_RETRY)) begin
                        w_nextRetry = r_retry + 8'd1;
                        w_nextCnt   = '0;
                        w_next      = S_HOLD;
                    end else begin
                        w_next = S_FATAL;
                    end
                end else if (!w_clean) begin
                    w_next = S_FATAL;
                end else if (r_cnt == CW'(VERIFY_CYCLES - 1)) begin
                    w_next = S_IDLE;
                end else begin
                    w_nextCnt = r_cnt + 1'b1;
                end
            end
            S_FATAL: w_next = S_FATAL;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs decode only registered state, so reset clears them immediately
    always_comb begin
        core_hold     = (r_state == S_HOLD) || (r_state == S_COPY) ||
                        (r_state == S_PCFIX) || (r_state == S_FATAL);
        Recovery_mode = (r_state == S_HOLD) || (r_state == S_COPY) || (r_state == S_PCFIX);
        fatal         = (r_state == S_FATAL);
        rf_addr       = (r_state == S_COPY) ? r_idx : 5'd0;
        rf_we_A       = (r_state == S_COPY) && r_fault[0];
        rf_we_B       = (r_state == S_COPY) && r_fault[1];
        rf_we_C       = (r_state == S_COPY) && r_fault[2];
        pc_we_A       = (r_state == S_PCFIX) && r_fault[0];
        pc_we_B       = (r_state == S_PCFIX) && r_fault[1];
        pc_we_C       = (r_state == S_PCFIX) && r_fault[2];
        rf_wd         = 32'd0;
        if (r_state == S_COPY) begin
            rf_wd = r_fault[0] ? rd_data_B : rd_data_A;
        end
    end

    logic w_unusedPc;
    assign w_unusedPc = ^PC_Top;

`ifdef RECOVERY_FAULT_LOG_EN
    logic       w_enterHold;
    logic [7:0] r_cntA, r_cntB, r_cntC;

    assign w_enterHold = (w_next == S_HOLD) && (r_state != S_HOLD);

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            r_cntA <= 8'd0;
            r_cntB <= 8'd0;
            r_cntC <= 8'd0;
        end else if (w_enterHold) begin
            if (w_nextFault[0] && r_cntA != 8'hFF) r_cntA <= r_cntA + 8'd1;
            if (w_nextFault[1] && r_cntB != 8'hFF) r_cntB <= r_cntB + 8'd1;
            if (w_nextFault[2] && r_cntC != 8'hFF) r_cntC <= r_cntC + 8'd1;
        end
    end

    assign fault_cnt_A = r_cntA;
    assign fault_cnt_B = r_cntB;
    assign fault_cnt_C = r_cntC;
`else
    assign fault_cnt_A = 8'd0;
    assign fault_cnt_B = 8'd0;
    assign fault_cnt_C = 8'd0;
`endif

endmodule

// File: tb/tb_tmr_recovery_sequencer.sv
// Bench for tmr_recovery_sequencer: directed scenarios then random voter traffic, checked
// against a frame-queue model of the recovery sequence.
module tb_tmr_recovery_sequencer;

   localparam int HOLD_CYCLES   = 2;
   localparam int VERIFY_CYCLES = 8;
   localparam int MAX_RETRY     = 2;
   localparam logic [31:0] BASE_A = 32'hA5A5_0000;
   localparam logic [31:0] BASE_B = 32'hB6B6_0000;
   localparam logic [31:0] BASE_C = 32'hC7C7_0000;

   logic        clk = 1'b0;
   logic        rst_in;
   logic [2:0]  Voter_state;
   logic [31:0] PC_Top;
   logic [31:0] rd_data_A, rd_data_B, rd_data_C;
   logic [4:0]  rf_addr;
   logic [31:0] rf_wd;
   logic        rf_we_A, rf_we_B, rf_we_C;
   logic        pc_we_A, pc_we_B, pc_we_C;
   logic        core_hold, Recovery_mode, fatal;
   logic [7:0]  fault_cnt_A, fault_cnt_B, fault_cnt_C;

   int nCompared = 0;
   int nMismatched = 0;
   int cycleNo = 0;

   // Reference model: a queue of pre-computed output frames for a recovery in flight,
   // plus the remaining verify window, retry count and fatal flag
   logic [45:0] expQ[$];
   int verifyLeft;
   bit mFatal;
   int mFault;
   int mRetry;
   int mCnt[3];
   logic [31:0] baseArr[3];

   tmr_recovery_sequencer #(
      .HOLD_CYCLES(HOLD_CYCLES),
      .VERIFY_CYCLES(VERIFY_CYCLES),
      .MAX_RETRY(MAX_RETRY)
   ) dut (
      .clk(clk), .rst_in(rst_in), .Voter_state(Voter_state), .PC_Top(PC_Top),
      .rd_data_A(rd_data_A), .rd_data_B(rd_data_B), .rd_data_C(rd_data_C),
      .rf_addr(rf_addr), .rf_wd(rf_wd),
      .rf_we_A(rf_we_A), .rf_we_B(rf_we_B), .rf_we_C(rf_we_C),
      .pc_we_A(pc_we_A), .pc_we_B(pc_we_B), .pc_we_C(pc_we_C),
      .core_hold(core_hold), .Recovery_mode(Recovery_mode), .fatal(fatal),
      .fault_cnt_A(fault_cnt_A), .fault_cnt_B(fault_cnt_B), .fault_cnt_C(fault_cnt_C)
   );

   always #5 clk = ~clk;

   // Each core's register file reads back a core-specific pattern plus the index
   assign rd_data_A = BASE_A + {27'd0, rf_addr};
   assign rd_data_B = BASE_B + {27'd0, rf_addr};
   assign rd_data_C = BASE_C + {27'd0, rf_addr};

   function automatic logic [45:0] mkFrame(bit hold, bit rec, bit fat, logic [2:0] rfwe,
                                           logic [2:0] pcwe, logic [4:0] addr, logic [31:0] wd);
      return {hold, rec, fat, rfwe, pcwe, addr, wd};
   endfunction

   function automatic logic [45:0] obsFrame();
      return {core_hold, Recovery_mode, fatal, {rf_we_C, rf_we_B, rf_we_A},
              {pc_we_C, pc_we_B, pc_we_A}, rf_addr, rf_wd};
   endfunction

   function automatic logic [23:0] expCnt();
`ifdef RECOVERY_FAULT_LOG_EN
      return {mCnt[2][7:0], mCnt[1][7:0], mCnt[0][7:0]};
`else
      return 24'd0;
`endif
   endfunction

   function automatic int oneHotIdx(logic [2:0] v);
      case (v)
         3'b001:  return 0;
         3'b010:  return 1;
         3'b100:  return 2;
         default: return -1;
      endcase
   endfunction

   function automatic logic [2:0] randVoter();
      int r;
      logic [2:0] one;
      r = $urandom_range(0, 99);
      one = 3'b001;
      if (r < 80) return 3'b000;
      if (r < 95) return one << $urandom_range(0, 2);
      case ($urandom_range(0, 3))
         0:       return 3'b011;
         1:       return 3'b101;
         2:       return 3'b110;
         default: return 3'b111;
      endcase
   endfunction

   // Single checking task: every comparison in the bench goes through here
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      nCompared++;
      if (observed !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s at cycle %0d: observed %h expected %h", tag, cycleNo, observed, expected);
      end
   endtask

   task automatic compareAll(input string tag, input logic [45:0] e);
      checkOutput(tag, {18'd0, obsFrame()}, {18'd0, e});
      checkOutput({tag, "_cnt"}, {40'd0, fault_cnt_C, fault_cnt_B, fault_cnt_A}, {40'd0, expCnt()});
   endtask

   // Queue the whole recovery: hold, copy x1..x31 from the lowest healthy core, PC fix, first verify cycle
   task automatic startRecovery(input int f);
      int s;
      logic [2:0] one;
      one = 3'b001;
      mFault = f;
      verifyLeft = 0;
      if (mCnt[f] < 255) mCnt[f]++;
      s = (f == 0) ? 1 : 0;
      for (int h = 0; h < HOLD_CYCLES; h++) expQ.push_back(mkFrame(1, 1, 0, 3'b000, 3'b000, 5'd0, 32'd0));
      for (int i = 1; i <= 31; i++)
         expQ.push_back(mkFrame(1, 1, 0, one << f, 3'b000, 5'(i), baseArr[s] + 32'(i)));
      expQ.push_back(mkFrame(1, 1, 0, 3'b000, one << f, 5'd0, 32'd0));
      expQ.push_back(mkFrame(0, 0, 0, 3'b000, 3'b000, 5'd0, 32'd0));
   endtask

   task automatic goFatal(output logic [45:0] e);
      mFatal = 1;
      verifyLeft = 0;
      expQ.delete();
      e = mkFrame(1, 0, 1, 3'b000, 3'b000, 5'd0, 32'd0);
   endtask

   task automatic modelStep(input logic [2:0] v, output logic [45:0] e);
      int k;
      k = oneHotIdx(v);
      e = '0;
      if (mFatal) begin
         e = mkFrame(1, 0, 1, 3'b000, 3'b000, 5'd0, 32'd0);
      end else if (expQ.size() != 0) begin
         e = expQ.pop_front();
         if (expQ.size() == 0) verifyLeft = VERIFY_CYCLES;
      end else if (v == 3'b000) begin
         if (verifyLeft > 0) verifyLeft--;
      end else if (k < 0) begin
         goFatal(e);
      end else if (verifyLeft > 0 && k == mFault) begin
         if (mRetry < MAX_RETRY) begin
            mRetry++;
            startRecovery(k);
            e = expQ.pop_front();
         end else begin
            goFatal(e);
         end
      end else begin
         mRetry = 1;
         startRecovery(k);
         e = expQ.pop_front();
      end
   endtask

   task automatic modelReset();
      expQ.delete();
      verifyLeft = 0;
      mFatal = 0;
      mFault = 0;
      mRetry = 0;
      for (int i = 0; i < 3; i++) mCnt[i] = 0;
   endtask

   task automatic applyStimulus(input logic [2:0] v, input string tag);
      logic [45:0] e;
      @(negedge clk);
      Voter_state = v;
      PC_Top = $urandom;
      @(posedge clk);
      #1;
      cycleNo++;
      modelStep(v, e);
      compareAll(tag, e);
   endtask

   // Asynchronous reset pulse placed mid-cycle; outputs must clear before any clock edge
   task automatic applyReset(input string tag);
      #2;
      rst_in = 1'b1;
      Voter_state = 3'b000;
      modelReset();
      #1;
      compareAll(tag, '0);
      @(negedge clk);
      rst_in = 1'b0;
   endtask

   task automatic drain(input string tag);
      while (expQ.size() != 0) applyStimulus(3'b000, tag);
   endtask

   initial begin
      baseArr[0] = BASE_A;
      baseArr[1] = BASE_B;
      baseArr[2] = BASE_C;
      rst_in = 1'b1;
      Voter_state = 3'b000;
      PC_Top = 32'h0040_1000;
      modelReset();
      #1;
      compareAll("reset", '0);
      @(negedge clk);
      rst_in = 1'b0;

      repeat (50) applyStimulus(3'b000, "idle");

      applyStimulus(3'b010, "faultB");
      drain("recoverB");
      repeat (VERIFY_CYCLES + 2) applyStimulus(3'b000, "verifyB");

      applyStimulus(3'b001, "faultA");
      drain("recoverA1");
      applyStimulus(3'b000, "verifyA1");
      applyStimulus(3'b001, "retryA");
      drain("recoverA2");
      applyStimulus(3'b001, "retryA_fatal");
      repeat (20) applyStimulus(3'b000, "fatalStable");
      applyReset("resetFromFatal");

      applyStimulus(3'b111, "noMajority");
      repeat (5) applyStimulus(3'b001, "fatalIgnoresVoter");
      applyReset("resetFromNoMaj");

      applyStimulus(3'b010, "faultB2");
      repeat (HOLD_CYCLES + 9) applyStimulus(3'b000, "copyB2");
      checkOutput("addrAtReset", {59'd0, rf_addr}, 64'd10);
      applyReset("midCopyReset");
      repeat (40) applyStimulus(3'b000, "postReset");

      for (int r = 0; r < 3; r++) begin
         applyStimulus(3'b100, "faultC");
         drain("recoverC");
         repeat (VERIFY_CYCLES) applyStimulus(3'b000, "verifyC");
      end
`ifdef RECOVERY_FAULT_LOG_EN
      checkOutput("cntC", {56'd0, fault_cnt_C}, 64'd3);
`else
      checkOutput("cntC", {56'd0, fault_cnt_C}, 64'd0);
`endif
      checkOutput("cntA", {56'd0, fault_cnt_A}, 64'd0);
      checkOutput("cntB", {56'd0, fault_cnt_B}, 64'd0);

      for (int c = 0; c < 4000; c++) begin
         if (mFatal ? ($urandom_range(0, 14) == 0) : ($urandom_range(0, 399) == 0))
            applyReset("randReset");
         else
            applyStimulus(randVoter(), "random");
      end

      $display("[TB] model fault events A/B/C since last reset = %0d/%0d/%0d", mCnt[0], mCnt[1], mCnt[2]);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
